// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: sequencer states and register-number width.
package cpu_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds the
// instruction currently in ID. Register 0 never creates a dependency.
module load_use_detect
    import cpu_ctrl_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard
);

    // Pure comparator; result is used in the same cycle by the sequencer.
    always_comb begin
        hazard = ex_mem_read && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: post-reset drain, load-use bubbles, branch
// squash, data-memory wait freeze, plus stall-cycle and timeout debug state.
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int INIT_FLUSH_CYCLES = 4,
    parameter int MEM_TIMEOUT       = 15,
    parameter int STALL_CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   startin_n,
    input  logic [REG_W-1:0]       ID_rs,
    input  logic [REG_W-1:0]       ID_rt,
    input  logic                   EX_mem_read,
    input  logic [REG_W-1:0]       EX_rt,
    input  logic                   MEM_branch,
    input  logic                   MEM_zero,
    input  logic                   MEM_mem_read,
    input  logic                   MEM_mem_write,
    input  logic                   dmem_ready,
    output logic                   pc_write,
    output logic                   IF_ID_write,
    output logic                   IF_ID_flush,
    output logic                   ID_EX_flush,
    output logic                   EX_MEM_flush,
    output logic                   EX_MEM_hold,
    output logic                   ctrl_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   mem_timeout
);

    localparam logic [3:0] DRAIN_INIT = 4'(INIT_FLUSH_CYCLES - 1);
    localparam logic [7:0] TMO_LAST   = 8'(MEM_TIMEOUT - 1);

    ctrl_state_t state, state_nxt;
    logic [3:0]  drain_cnt;
    logic [7:0]  wait_cnt;
    logic        load_use;
    logic        mem_stall;
    logic        branch_taken;

    load_use_detect u_load_use_detect (
        .ex_mem_read (EX_mem_read),
        .ex_rt       (EX_rt),
        .id_rs       (ID_rs),
        .id_rt       (ID_rt),
        .hazard      (load_use)
    );

    assign mem_stall    = (MEM_mem_read || MEM_mem_write) && !dmem_ready;
    assign branch_taken = MEM_branch && MEM_zero;
    assign ctrl_busy    = (state != RUN);

    // Next state and zero-latency pipeline controls. RUN and MEM_WAIT share
    // the same rules: a still-pending access keeps waiting, anything else
    // (ready, or strobes dropped) resolves through the normal hazard order.
    always_comb begin
        state_nxt    = state;
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        EX_MEM_hold  = 1'b0;
        case (state)
            INIT: begin
                IF_ID_flush  = 1'b1;
                ID_EX_flush  = 1'b1;
                EX_MEM_flush = 1'b1;
                if (drain_cnt == 4'd0) state_nxt = RUN;
            end
            default: begin
                if (mem_stall) begin
                    EX_MEM_hold = 1'b1;
                    state_nxt   = MEM_WAIT;
                end else begin
                    state_nxt = RUN;
                    if (branch_taken) begin
                        pc_write     = 1'b1;
                        IF_ID_write  = 1'b1;
                        IF_ID_flush  = 1'b1;
                        ID_EX_flush  = 1'b1;
                        EX_MEM_flush = 1'b1;
                    end else if (load_use) begin
                        ID_EX_flush = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        IF_ID_write = 1'b1;
                    end
                end
            end
        endcase
    end

    // State register and post-reset drain countdown.
    always_ff @(posedge clk or negedge startin_n) begin
        if (!startin_n) begin
            state     <= INIT;
            drain_cnt <= DRAIN_INIT;
        end else begin
            state <= state_nxt;
            if (state == INIT && drain_cnt != 4'd0) drain_cnt <= drain_cnt - 4'd1;
        end
    end

    // Memory wait counter and sticky timeout; the wait itself never aborts.
    always_ff @(posedge clk or negedge startin_n) begin
        if (!startin_n) begin
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else if (state == MEM_WAIT) begin
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == TMO_LAST) mem_timeout <= 1'b1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge startin_n) begin
        if (!startin_n) begin
            stall_cycles <= '0;
        end else if (!pc_write && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        startin_n;
    logic [4:0]  ID_rs, ID_rt, EX_rt;
    logic        EX_mem_read, MEM_branch, MEM_zero;
    logic        MEM_mem_read, MEM_mem_write, dmem_ready;
    logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush;
    logic        EX_MEM_hold, ctrl_busy, mem_timeout;
    logic [15:0] stall_cycles;

    int errors = 0;
    int checks = 0;
    int exp_stall = 0;

    pipeline_hazard_ctrl dut (
        .clk           (clk),
        .startin_n     (startin_n),
        .ID_rs         (ID_rs),
        .ID_rt         (ID_rt),
        .EX_mem_read   (EX_mem_read),
        .EX_rt         (EX_rt),
        .MEM_branch    (MEM_branch),
        .MEM_zero      (MEM_zero),
        .MEM_mem_read  (MEM_mem_read),
        .MEM_mem_write (MEM_mem_write),
        .dmem_ready    (dmem_ready),
        .pc_write      (pc_write),
        .IF_ID_write   (IF_ID_write),
        .IF_ID_flush   (IF_ID_flush),
        .ID_EX_flush   (ID_EX_flush),
        .EX_MEM_flush  (EX_MEM_flush),
        .EX_MEM_hold   (EX_MEM_hold),
        .ctrl_busy     (ctrl_busy),
        .stall_cycles  (stall_cycles),
        .mem_timeout   (mem_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0; EX_mem_read = 1'b0;
        MEM_branch = 1'b0; MEM_zero = 1'b0;
        MEM_mem_read = 1'b0; MEM_mem_write = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic chk_init_outputs(input string tag);
        chk({tag, "_pc_write"}, pc_write, 0);
        chk({tag, "_if_id_write"}, IF_ID_write, 0);
        chk({tag, "_flushes"}, {IF_ID_flush, ID_EX_flush, EX_MEM_flush}, 3'b111);
        chk({tag, "_hold"}, EX_MEM_hold, 0);
        chk({tag, "_busy"}, ctrl_busy, 1);
    endtask

    // Release reset and walk through the four drain cycles into RUN.
    task automatic release_and_drain(input string tag);
        startin_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_init_outputs($sformatf("%s_drain%0d", tag, i));
            tick();
        end
        #1;
        chk({tag, "_run_busy"}, ctrl_busy, 0);
        chk({tag, "_run_pc_write"}, pc_write, 1);
        chk({tag, "_run_stall_cnt"}, stall_cycles, 4);
        exp_stall = 4;
    endtask

    initial begin
        idle_inputs();
        startin_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Held in reset
        chk_init_outputs("reset");
        chk("reset_stall_cnt", stall_cycles, 0);
        chk("reset_timeout", mem_timeout, 0);

        release_and_drain("boot");

        // Load-use through rs: one bubble
        EX_mem_read = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5; #1;
        chk("lu_rs_pc_write", pc_write, 0);
        chk("lu_rs_if_id_write", IF_ID_write, 0);
        chk("lu_rs_id_ex_flush", ID_EX_flush, 1);
        chk("lu_rs_if_id_flush", IF_ID_flush, 0);
        chk("lu_rs_ex_mem_flush", EX_MEM_flush, 0);
        tick(); exp_stall++;
        idle_inputs(); #1;
        chk("lu_after_pc_write", pc_write, 1);
        chk("lu_after_stall_cnt", stall_cycles, exp_stall);

        // Load-use through rt
        EX_mem_read = 1'b1; EX_rt = 5'd7; ID_rt = 5'd7; ID_rs = 5'd3; #1;
        chk("lu_rt_pc_write", pc_write, 0);
        chk("lu_rt_id_ex_flush", ID_EX_flush, 1);
        tick(); exp_stall++;

        // Register 0 never stalls
        EX_mem_read = 1'b1; EX_rt = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0; #1;
        chk("lu_r0_pc_write", pc_write, 1);
        chk("lu_r0_id_ex_flush", ID_EX_flush, 0);
        // Non-matching register
        EX_rt = 5'd5; ID_rs = 5'd6; ID_rt = 5'd4; #1;
        chk("lu_nomatch_pc_write", pc_write, 1);
        // Matching register but not a load
        EX_mem_read = 1'b0; ID_rs = 5'd5; #1;
        chk("lu_noload_pc_write", pc_write, 1);
        tick();

        // Taken branch overrides load-use
        EX_mem_read = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5;
        MEM_branch = 1'b1; MEM_zero = 1'b1; #1;
        chk("br_pc_write", pc_write, 1);
        chk("br_flushes", {IF_ID_flush, ID_EX_flush, EX_MEM_flush}, 3'b111);
        chk("br_hold", EX_MEM_hold, 0);
        // Branch not taken falls back to the load-use bubble
        MEM_zero = 1'b0; #1;
        chk("br_nt_pc_write", pc_write, 0);
        chk("br_nt_flushes", {IF_ID_flush, ID_EX_flush, EX_MEM_flush}, 3'b010);
        idle_inputs();
        tick();
        chk("br_after_stall_cnt", stall_cycles, exp_stall);

        // Load in MEM waiting three cycles
        MEM_mem_read = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_hold%0d", i), EX_MEM_hold, 1);
            chk($sformatf("mw_pc_write%0d", i), pc_write, 0);
            chk($sformatf("mw_if_id_write%0d", i), IF_ID_write, 0);
            chk($sformatf("mw_flushes%0d", i), {IF_ID_flush, ID_EX_flush, EX_MEM_flush}, 3'b000);
            chk($sformatf("mw_busy%0d", i), ctrl_busy, (i > 0) ? 1 : 0);
            tick(); exp_stall++;
        end
        dmem_ready = 1'b1; #1;
        chk("mw_ready_hold", EX_MEM_hold, 0);
        chk("mw_ready_pc_write", pc_write, 1);
        chk("mw_ready_busy", ctrl_busy, 1);
        tick();
        idle_inputs(); #1;
        chk("mw_done_busy", ctrl_busy, 0);
        chk("mw_done_stall_cnt", stall_cycles, exp_stall);
        chk("mw_done_timeout", mem_timeout, 0);

        // Long wait: 1 RUN stall cycle then 19 MEM_WAIT cycles; the flag is
        // first visible in the cycle after the 15th MEM_WAIT cycle.
        MEM_mem_write = 1'b1; dmem_ready = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            chk($sformatf("tmo_flag_c%0d", c), mem_timeout, (c >= 17) ? 1 : 0);
            tick(); exp_stall++;
        end
        dmem_ready = 1'b1; #1;
        chk("tmo_ready_hold", EX_MEM_hold, 0);
        tick();
        idle_inputs(); #1;
        chk("tmo_sticky", mem_timeout, 1);
        chk("tmo_busy", ctrl_busy, 0);
        chk("tmo_stall_cnt", stall_cycles, exp_stall);
        tick(); #1;
        chk("tmo_sticky2", mem_timeout, 1);

        // Strobes dropping mid-wait return to RUN
        MEM_mem_read = 1'b1; dmem_ready = 1'b0;
        tick(); tick();
        MEM_mem_read = 1'b0; #1;
        chk("drop_pc_write", pc_write, 1);
        chk("drop_busy", ctrl_busy, 1);
        tick(); #1;
        chk("drop_run_busy", ctrl_busy, 0);

        // Asynchronous reset in the middle of a memory wait
        MEM_mem_read = 1'b1; dmem_ready = 1'b0;
        tick(); tick();
        #2;
        startin_n = 1'b0;
        #1;
        chk_init_outputs("areset");
        chk("areset_stall_cnt", stall_cycles, 0);
        chk("areset_timeout", mem_timeout, 0);
        idle_inputs();
        tick();
        release_and_drain("reboot");
        chk("reboot_timeout", mem_timeout, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
